// File: rtl/access_ctrl_gen2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : access_ctrl_pkg
//  Description : Shared types and constants for the key-gated access
//                controller: key FSM states, flow FSM states and the Moore
//                output encoding of each flow state.
//  Revision    : 1.0 - initial release
// ============================================================================
package access_ctrl_pkg;

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        ACTIVE  = 2'd1,
        LOCKOUT = 2'd2
    } key_state_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_ACC = 3'd1,
        WR     = 3'd2,
        SAMPLE = 3'd3,
        TX     = 3'd4
    } flow_state_t;

    // Output encoding, ordered {AccessMem, RWMem, SampleData, TxData, Busy}
    localparam logic [4:0] c_OUT_IDLE   = 5'b00000;
    localparam logic [4:0] c_OUT_RD_ACC = 5'b10001;
    localparam logic [4:0] c_OUT_WR     = 5'b11001;
    localparam logic [4:0] c_OUT_SAMPLE = 5'b00101;
    localparam logic [4:0] c_OUT_TX     = 5'b00011;

endpackage
`default_nettype wire

// File: rtl/access_ctrl_gen2_if.sv
`default_nettype none
// ============================================================================
//  Module      : access_ctrl_gen2_if
//  Description : Command/datapath bundle of the access controller.
//                master : command front end + datapath blocks (drive key,
//                         command, txDone and relock; observe strobes)
//                slave  : the access controller itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface access_ctrl_gen2_if;
    import access_ctrl_pkg::*;

    // Front end -> controller
    logic inputKey;
    logic validCmd;
    logic RW;
    logic txDone;
    logic relock;

    // Controller -> front end / datapath
    logic active;
    logic mode;
    logic lockedOut;
    logic AccessMem;
    logic RWMem;
    logic SampleData;
    logic TxData;
    logic Busy;
    logic txTimeout;

    modport master (
        output inputKey, validCmd, RW, txDone, relock,
        input  active, mode, lockedOut, AccessMem, RWMem, SampleData,
               TxData, Busy, txTimeout
    );

    modport slave (
        input  inputKey, validCmd, RW, txDone, relock,
        output active, mode, lockedOut, AccessMem, RWMem, SampleData,
               TxData, Busy, txTimeout
    );
endinterface
`default_nettype wire

// File: rtl/access_ctrl_gen2_key_unlock.sv
`default_nettype none
// ============================================================================
//  Module      : key_unlock
//  Description : Serial key entry / lockout state machine.
//                Key bits arrive LSB first on validCmd; the strobe after the
//                last key bit carries the mode bit and triggers evaluation.
//                MAX_TRIES consecutive failures hold the block in lockout
//                for LOCK_CYCLES cycles.
//  Ports       : clk, reset           - clock, synchronous active-high reset
//                inputKey, validCmd   - serial bit and its qualifier
//                relock               - return to key entry (level)
//                flowIdle             - command flow is idle (relock gate)
//                active, mode         - unlocked flag, last accepted mode bit
//                lockedOut            - lockout in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module key_unlock
    import access_ctrl_pkg::*;
#(
    parameter int                 KEY_LEN     = 4,
    parameter logic [KEY_LEN-1:0] KEY_VALUE   = 4'b0101,
    parameter int                 MAX_TRIES   = 3,
    parameter int                 LOCK_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic inputKey,
    input  logic validCmd,
    input  logic relock,
    input  logic flowIdle,
    output logic active,
    output logic mode,
    output logic lockedOut
);

    localparam int IDX_W  = $clog2(KEY_LEN + 1);
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

    localparam logic [IDX_W-1:0]  c_IDX_MODE  = IDX_W'(KEY_LEN);
    localparam logic [FAIL_W-1:0] c_FAIL_LAST = FAIL_W'(MAX_TRIES - 1);
    localparam logic [LOCK_W-1:0] c_LOCK_LOAD = LOCK_W'(LOCK_CYCLES);
    localparam logic [LOCK_W-1:0] c_LOCK_ONE  = LOCK_W'(1);

    key_state_t         r_state;
    logic [KEY_LEN-1:0] r_key;
    logic [IDX_W-1:0]   r_idx;
    logic [FAIL_W-1:0]  r_fail;
    logic [LOCK_W-1:0]  r_lock;
    logic               r_active;
    logic               r_mode;
    logic               r_locked;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ENTRY;
            r_key    <= '0;
            r_idx    <= '0;
            r_fail   <= '0;
            r_lock   <= '0;
            r_active <= 1'b0;
            r_mode   <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            case (r_state)
                ENTRY: begin
                    if (validCmd) begin
                        if (r_idx != c_IDX_MODE) begin
                            for (int i = 0; i < KEY_LEN; i++) begin
                                if (r_idx == IDX_W'(i)) begin
                                    r_key[i] <= inputKey;
                                end
                            end
                            r_idx <= r_idx + IDX_W'(1);
                        end else if (r_key == KEY_VALUE) begin
                            r_state  <= ACTIVE;
                            r_idx    <= '0;
                            r_fail   <= '0;
                            r_active <= 1'b1;
                            r_mode   <= inputKey;
                        end else begin
                            r_idx  <= '0;
                            r_fail <= r_fail + FAIL_W'(1);
                            if (r_fail == c_FAIL_LAST) begin
                                r_state  <= LOCKOUT;
                                r_lock   <= c_LOCK_LOAD;
                                r_locked <= 1'b1;
                            end
                        end
                    end
                end

                ACTIVE: begin
                    // Relock only takes effect between commands; it also
                    // beats a command strobe arriving in the same cycle.
                    if (flowIdle && relock) begin
                        r_state  <= ENTRY;
                        r_idx    <= '0;
                        r_fail   <= '0;
                        r_active <= 1'b0;
                        r_mode   <= 1'b0;
                    end else if (flowIdle && validCmd) begin
                        r_mode <= inputKey;
                    end
                end

                LOCKOUT: begin
                    // Counter loaded with LOCK_CYCLES on entry; leaving on the
                    // edge that sees 1 gives exactly LOCK_CYCLES locked cycles.
                    if (r_lock == c_LOCK_ONE) begin
                        r_state  <= ENTRY;
                        r_lock   <= '0;
                        r_fail   <= '0;
                        r_locked <= 1'b0;
                    end else begin
                        r_lock <= r_lock - LOCK_W'(1);
                    end
                end

                default: begin
                    r_state  <= ENTRY;
                    r_idx    <= '0;
                    r_fail   <= '0;
                    r_lock   <= '0;
                    r_active <= 1'b0;
                    r_mode   <= 1'b0;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign active    = r_active;
    assign mode      = r_mode;
    assign lockedOut = r_locked;

endmodule
`default_nettype wire

// File: rtl/access_ctrl_gen2.sv
`default_nettype none
// ============================================================================
//  Module      : access_ctrl_gen2
//  Description : Key-gated access controller. key_unlock arbitrates access;
//                once unlocked, a Moore flow FSM sequences the memory,
//                sample and transmit strobes and bounds the TX wait.
//  Ports       : clk    - clock, rising edge
//                reset  - synchronous, active-high
//                bus    - access_ctrl_gen2_if.slave: inputKey, validCmd, RW,
//                         txDone, relock in; active, mode, lockedOut,
//                         AccessMem, RWMem, SampleData, TxData, Busy,
//                         txTimeout out
//  Revision    : 1.0 - initial release
// ============================================================================
module access_ctrl_gen2
    import access_ctrl_pkg::*;
#(
    parameter int                 KEY_LEN     = 4,
    parameter logic [KEY_LEN-1:0] KEY_VALUE   = 4'b0101,
    parameter int                 MAX_TRIES   = 3,
    parameter int                 LOCK_CYCLES = 16,
    parameter int                 TX_TIMEOUT  = 64
) (
    input  logic               clk,
    input  logic               reset,
    access_ctrl_gen2_if.slave  bus
);

    localparam int              TO_W      = $clog2(TX_TIMEOUT + 1);
    localparam logic [TO_W-1:0] c_TX_LAST = TO_W'(TX_TIMEOUT - 1);

    flow_state_t     r_flow;
    logic [4:0]      r_outs;
    logic [TO_W-1:0] r_tx_cnt;
    logic            r_tx_timeout;

    logic            w_flow_idle;
    logic            w_active;
    logic            w_mode;
    logic            w_locked;

    assign w_flow_idle = (r_flow == IDLE);

    key_unlock #(
        .KEY_LEN     (KEY_LEN),
        .KEY_VALUE   (KEY_VALUE),
        .MAX_TRIES   (MAX_TRIES),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_key_unlock (
        .clk       (clk),
        .reset     (reset),
        .inputKey  (bus.inputKey),
        .validCmd  (bus.validCmd),
        .relock    (bus.relock),
        .flowIdle  (w_flow_idle),
        .active    (w_active),
        .mode      (w_mode),
        .lockedOut (w_locked)
    );

    // Outputs are registered alongside the state so each strobe is a clean
    // flop output for the datapath blocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flow       <= IDLE;
            r_outs       <= c_OUT_IDLE;
            r_tx_cnt     <= '0;
            r_tx_timeout <= 1'b0;
        end else begin
            r_tx_timeout <= 1'b0;
            case (r_flow)
                IDLE: begin
                    if (w_active && bus.validCmd && !bus.relock) begin
                        if (!bus.inputKey) begin
                            r_flow <= SAMPLE;
                            r_outs <= c_OUT_SAMPLE;
                        end else if (bus.RW) begin
                            r_flow <= WR;
                            r_outs <= c_OUT_WR;
                        end else begin
                            r_flow <= RD_ACC;
                            r_outs <= c_OUT_RD_ACC;
                        end
                    end
                end

                RD_ACC: begin
                    r_flow <= SAMPLE;
                    r_outs <= c_OUT_SAMPLE;
                end

                WR: begin
                    r_flow <= IDLE;
                    r_outs <= c_OUT_IDLE;
                end

                SAMPLE: begin
                    r_flow   <= TX;
                    r_outs   <= c_OUT_TX;
                    r_tx_cnt <= '0;
                end

                TX: begin
                    // txDone has priority so a completion on the final
                    // allowed cycle is not reported as a timeout.
                    if (bus.txDone) begin
                        r_flow <= IDLE;
                        r_outs <= c_OUT_IDLE;
                    end else if (r_tx_cnt == c_TX_LAST) begin
                        r_flow       <= IDLE;
                        r_outs       <= c_OUT_IDLE;
                        r_tx_timeout <= 1'b1;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + TO_W'(1);
                    end
                end

                default: begin
                    r_flow <= IDLE;
                    r_outs <= c_OUT_IDLE;
                end
            endcase
        end
    end

    assign bus.active     = w_active;
    assign bus.mode       = w_mode;
    assign bus.lockedOut  = w_locked;
    assign bus.AccessMem  = r_outs[4];
    assign bus.RWMem      = r_outs[3];
    assign bus.SampleData = r_outs[2];
    assign bus.TxData     = r_outs[1];
    assign bus.Busy       = r_outs[0];
    assign bus.txTimeout  = r_tx_timeout;

endmodule
`default_nettype wire

// File: tb/tb_access_ctrl_gen2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_access_ctrl_gen2
//  Description : Scoreboard bench for access_ctrl_gen2. Stimulus pushes the
//                expected output vector for each driven edge; a monitor pops
//                and compares on the following falling edge.
//                Vector order: {active, mode, lockedOut, AccessMem, RWMem,
//                SampleData, TxData, Busy, txTimeout}
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_access_ctrl_gen2;

    localparam logic [4:0] F_IDLE = 5'b00000;
    localparam logic [4:0] F_RD   = 5'b10001;
    localparam logic [4:0] F_WR   = 5'b11001;
    localparam logic [4:0] F_SMP  = 5'b00101;
    localparam logic [4:0] F_TX   = 5'b00011;

    typedef struct {
        int         cyc;
        logic [8:0] vec;
        string      nm;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t e_mon;
    logic [8:0] obs;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    access_ctrl_gen2_if bus();

    access_ctrl_gen2 #(
        .KEY_LEN     (4),
        .KEY_VALUE   (4'b0101),
        .MAX_TRIES   (3),
        .LOCK_CYCLES (16),
        .TX_TIMEOUT  (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign obs = {bus.active, bus.mode, bus.lockedOut, bus.AccessMem,
                  bus.RWMem, bus.SampleData, bus.TxData, bus.Busy,
                  bus.txTimeout};

    function automatic logic [8:0] V(input logic a, input logic m,
                                     input logic lo, input logic [4:0] f,
                                     input logic to);
        return {a, m, lo, f, to};
    endfunction

    // Monitor: compares every expectation tagged with the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e_mon = sb.pop_front();
            n_checks++;
            if (e_mon.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d seen at cycle %0d",
                         e_mon.nm, e_mon.cyc, cyc);
            end else if (obs !== e_mon.vec) begin
                n_fail++;
                $display("FAIL %s @cycle %0d: got %b expected %b",
                         e_mon.nm, cyc, obs, e_mon.vec);
            end
        end
    end

    // Drive one cycle of inputs (sampled at the next rising edge) and
    // record the outputs expected after that edge.
    task automatic step(input logic r, input logic vc, input logic ik,
                        input logic rw, input logic td, input logic rl,
                        input logic [8:0] v, input string nm);
        exp_t e;
        @(negedge clk);
        reset        = r;
        bus.validCmd = vc;
        bus.inputKey = ik;
        bus.RW       = rw;
        bus.txDone   = td;
        bus.relock   = rl;
        e.cyc = cyc + 1;
        e.vec = v;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic idle(input logic [8:0] v, input string nm);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, v, nm);
    endtask

    task automatic enter_key(input logic [3:0] k, input logic mb,
                             input logic [8:0] vfinal, input string nm);
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, k[i], 1'b0, 1'b0, 1'b0, 9'b0, nm);
        step(1'b0, 1'b1, mb, 1'b0, 1'b0, 1'b0, vfinal, nm);
    endtask

    task automatic rd_cmd(input string nm);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, V(1, 1, 0, F_RD, 0), nm);
        idle(V(1, 1, 0, F_SMP, 0), nm);
    endtask

    initial begin
        bus.inputKey = 1'b0;
        bus.validCmd = 1'b0;
        bus.RW       = 1'b0;
        bus.txDone   = 1'b0;
        bus.relock   = 1'b0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b0, "reset0");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b0, "reset1");
        idle(9'b0, "post_reset");

        // Unlock with 1,0,1,0 + mode 1
        enter_key(4'b0101, 1'b1, V(1, 1, 0, F_IDLE, 0), "unlock");
        idle(V(1, 1, 0, F_IDLE, 0), "unlock_hold");

        // Read: RD_ACC, SAMPLE, TX x3, txDone -> IDLE
        rd_cmd("rd");
        repeat (3) idle(V(1, 1, 0, F_TX, 0), "rd_tx");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V(1, 1, 0, F_IDLE, 0), "rd_done");

        // Write: single WR cycle, command during Busy dropped and not queued
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, V(1, 1, 0, F_WR, 0), "wr");
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V(1, 1, 0, F_IDLE, 0), "wr_busy_ignored");
        idle(V(1, 1, 0, F_IDLE, 0), "wr_no_queue");

        // Sample (mode 0); txDone outside TX ignored
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V(1, 0, 0, F_SMP, 0), "smp");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V(1, 0, 0, F_TX, 0), "smp_txdone_early");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V(1, 0, 0, F_IDLE, 0), "smp_done");

        // TX timeout: 64 TX cycles, one-cycle pulse
        rd_cmd("to");
        repeat (64) idle(V(1, 1, 0, F_TX, 0), "to_tx");
        idle(V(1, 1, 0, F_IDLE, 1), "to_pulse");
        idle(V(1, 1, 0, F_IDLE, 0), "to_pulse_end");

        // txDone on the timeout edge is a normal completion
        rd_cmd("to_edge");
        repeat (64) idle(V(1, 1, 0, F_TX, 0), "to_edge_tx");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V(1, 1, 0, F_IDLE, 0), "to_edge_done");
        idle(V(1, 1, 0, F_IDLE, 0), "to_edge_no_pulse");

        // Relock held through a busy command, honoured once IDLE
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, V(1, 1, 0, F_RD, 0), "rl_rd");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, V(1, 1, 0, F_SMP, 0), "rl_busy_smp");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, V(1, 1, 0, F_TX, 0), "rl_busy_tx");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, V(1, 1, 0, F_TX, 0), "rl_busy_tx");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, V(1, 1, 0, F_IDLE, 0), "rl_tx_done");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'b0, "rl_taken");
        idle(9'b0, "rl_entry");

        // Relock beats a same-cycle command
        enter_key(4'b0101, 1'b0, V(1, 0, 0, F_IDLE, 0), "unlock2");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 9'b0, "relock_wins");
        idle(9'b0, "relock_wins_idle");

        // Three wrong keys -> 16-cycle lockout, strobes ignored
        enter_key(4'b1111, 1'b1, 9'b0, "wrong1");
        enter_key(4'b1111, 1'b1, 9'b0, "wrong2");
        enter_key(4'b1111, 1'b1, V(0, 0, 1, F_IDLE, 0), "wrong3");
        for (int i = 1; i < 16; i++)
            step(1'b0, 1'b1, i[0], 1'b0, 1'b0, 1'b0, V(0, 0, 1, F_IDLE, 0), "lockout_hold");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'b0, "lockout_end");
        enter_key(4'b0011, 1'b0, 9'b0, "post_lock_wrong");
        enter_key(4'b0101, 1'b1, V(1, 1, 0, F_IDLE, 0), "post_lock_unlock");

        // Reset mid-RD_ACC, then a command strobe cannot start anything
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, V(1, 1, 0, F_RD, 0), "rst_rd");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'b0, "rst_mid");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'b0, "post_rst_cmd");
        idle(9'b0, "post_rst_idle");

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
